// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 receive path.
//   ps2_state_t      frame FSM encoding (IDLE=0, DATA=1, PARITY=2, STOP=3)
//   PS2_PREFIX_EXT   extended-key prefix byte (E0)
//   PS2_PREFIX_BRK   key-release prefix byte (F0)
//   PS2_FRAME_BITS   bits per device-to-host frame (start, 8 data, parity, stop)
//   odd_parity_ok()  odd-parity check over a data byte plus its parity bit
// ---------------------------------------------------------------------------
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_t;

   localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
   localparam int         PS2_FRAME_BITS = 11;

   // Returns 1 when byte and parity together hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] byte_v, input logic par_v);
      return ^{byte_v, par_v};
   endfunction

endpackage

// File: rtl/ps2_pin_filter.sv
// ---------------------------------------------------------------------------
// ps2_pin_filter
// Synchronises one raw PS/2 pin, de-glitches it, and flags falling edges.
//   clk          system clock
//   reset        asynchronous active-low reset (filtered level resets high)
//   pin          raw asynchronous pin, idle high
//   fall_strobe  1-cycle pulse when the filtered level goes 1 -> 0
// The filtered level changes only after FILTER_LEN consecutive synchronised
// samples disagree with it; any agreeing sample restarts the count.
// ---------------------------------------------------------------------------
module ps2_pin_filter
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic fall_strobe
);

   localparam int             CW       = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_LEN - 1);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   sync_s;
   logic                   level_r;
   logic [CW-1:0]          flt_cnt_r;
   logic                   strobe_r;

   assign sync_s      = sync_r[SYNC_STAGES-1];
   assign fall_strobe = strobe_r;

   // Metastability chain, reset to the idle-high pin level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_r <= '1;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], pin};
      end
   end

   // Glitch filter and registered falling-edge strobe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         level_r   <= 1'b1;
         flt_cnt_r <= '0;
         strobe_r  <= 1'b0;
      end else begin
         strobe_r <= 1'b0;
         if (sync_s == level_r) begin
            flt_cnt_r <= '0;
         end else if (flt_cnt_r == CNT_LAST) begin
            level_r   <= sync_s;
            flt_cnt_r <= '0;
            // Old level 1 means this accepted change is a falling edge.
            strobe_r  <= level_r;
         end else begin
            flt_cnt_r <= flt_cnt_r + CW'(1);
         end
      end
   end

endmodule

// File: rtl/ps2_frame_receiver.sv
// ---------------------------------------------------------------------------
// ps2_frame_receiver
// PS/2 front end: pin conditioning plus 11-bit device-to-host frame
// deserialiser delivering parity/stop-checked scan bytes.
//   clk         system clock (100 MHz nominal)
//   reset       asynchronous active-low reset
//   PS2_clk     raw PS/2 clock pin, idle high
//   PS2_dat     raw PS/2 data pin, idle high
//   data        last good scan byte, held until the next good byte
//   data_valid  1-cycle pulse, data updated
//   parity_err  1-cycle pulse, frame dropped on odd-parity failure
//   frame_err   1-cycle pulse, frame dropped on bad stop bit or timeout
//   released    break prefix (F0) preceded data
//   extended    E0 prefix preceded data
// Optional macro PS2_BREAK_DECODE_EN: absorbs E0/F0 prefix bytes into the
// released/extended qualifiers. Without it every good byte is emitted raw
// and released/extended are tied 0.
// ---------------------------------------------------------------------------
module ps2_frame_receiver
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 100_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       PS2_clk,
   input  logic       PS2_dat,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       released,
   output logic       extended
);

   localparam int            DATA_BITS = PS2_FRAME_BITS - 3;
   localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
   localparam int            TW        = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYC);

   logic                   strobe_s;
   logic [SYNC_STAGES-1:0] dat_sync_r;
   logic                   dat_s;

   ps2_state_t    state_r;
   logic [2:0]    bit_cnt_r;
   logic [7:0]    shift_r;
   logic          parity_r;
   logic [TW-1:0] to_cnt_r;
   logic [7:0]    data_r;
   logic          dv_r;
   logic          pe_r;
   logic          fe_r;
`ifdef PS2_BREAK_DECODE_EN
   logic          rel_r;
   logic          ext_r;
   logic          pend_ext_r;
   logic          pend_brk_r;
`endif

   ps2_pin_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_clk_filter (
      .clk         (clk),
      .reset       (reset),
      .pin         (PS2_clk),
      .fall_strobe (strobe_s)
   );

   assign dat_s = dat_sync_r[SYNC_STAGES-1];

   // Data pin needs synchronisation only; it is sampled on the clock strobe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dat_sync_r <= '1;
      end else begin
         dat_sync_r <= {dat_sync_r[SYNC_STAGES-2:0], PS2_dat};
      end
   end

   // Frame FSM, inter-bit timeout and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= IDLE;
         bit_cnt_r  <= 3'd0;
         shift_r    <= 8'h00;
         parity_r   <= 1'b0;
         to_cnt_r   <= '0;
         data_r     <= 8'h00;
         dv_r       <= 1'b0;
         pe_r       <= 1'b0;
         fe_r       <= 1'b0;
`ifdef PS2_BREAK_DECODE_EN
         rel_r      <= 1'b0;
         ext_r      <= 1'b0;
         pend_ext_r <= 1'b0;
         pend_brk_r <= 1'b0;
`endif
      end else begin
         dv_r <= 1'b0;
         pe_r <= 1'b0;
         fe_r <= 1'b0;
         // A strobe always wins over a coincident timeout.
         if (strobe_s) begin
            to_cnt_r <= '0;
            case (state_r)
               IDLE: begin
                  // A high data bit here is a spurious edge and is ignored.
                  if (!dat_s) begin
                     state_r   <= DATA;
                     bit_cnt_r <= 3'd0;
                  end
               end
               DATA: begin
                  shift_r   <= {dat_s, shift_r[7:1]};
                  bit_cnt_r <= bit_cnt_r + 3'd1;
                  if (bit_cnt_r == LAST_BIT) begin
                     state_r <= PARITY;
                  end
               end
               PARITY: begin
                  parity_r <= dat_s;
                  state_r  <= STOP;
               end
               STOP: begin
                  state_r <= IDLE;
                  if (!dat_s) begin
                     fe_r <= 1'b1;
`ifdef PS2_BREAK_DECODE_EN
                     pend_ext_r <= 1'b0;
                     pend_brk_r <= 1'b0;
`endif
                  end else if (!odd_parity_ok(shift_r, parity_r)) begin
                     pe_r <= 1'b1;
`ifdef PS2_BREAK_DECODE_EN
                     pend_ext_r <= 1'b0;
                     pend_brk_r <= 1'b0;
`endif
                  end else begin
`ifdef PS2_BREAK_DECODE_EN
                     if (shift_r == PS2_PREFIX_EXT) begin
                        pend_ext_r <= 1'b1;
                     end else if (shift_r == PS2_PREFIX_BRK) begin
                        pend_brk_r <= 1'b1;
                     end else begin
                        data_r     <= shift_r;
                        dv_r       <= 1'b1;
                        rel_r      <= pend_brk_r;
                        ext_r      <= pend_ext_r;
                        pend_ext_r <= 1'b0;
                        pend_brk_r <= 1'b0;
                     end
`else
                     data_r <= shift_r;
                     dv_r   <= 1'b1;
`endif
                  end
               end
               default: begin
                  state_r <= IDLE;
               end
            endcase
         end else if (state_r != IDLE) begin
            if (to_cnt_r == TO_LAST) begin
               // Counter reaches TIMEOUT_CYC on this edge: abandon the frame.
               fe_r     <= 1'b1;
               state_r  <= IDLE;
               to_cnt_r <= TO_MAX;
`ifdef PS2_BREAK_DECODE_EN
               pend_ext_r <= 1'b0;
               pend_brk_r <= 1'b0;
`endif
            end else if (to_cnt_r != TO_MAX) begin
               to_cnt_r <= to_cnt_r + TW'(1);
            end
         end
      end
   end

   assign data       = data_r;
   assign data_valid = dv_r;
   assign parity_err = pe_r;
   assign frame_err  = fe_r;
`ifdef PS2_BREAK_DECODE_EN
   assign released   = rel_r;
   assign extended   = ext_r;
`else
   assign released   = 1'b0;
   assign extended   = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// ---------------------------------------------------------------------------
// tb_ps2_frame_receiver
// Directed bench for ps2_frame_receiver. PS/2 timing is scaled so a run stays
// short: 80-cycle bit period, TIMEOUT_CYC = 500. Data changes mid-low-phase.
// Expected results depend on macro PS2_BREAK_DECODE_EN for the prefix test.
// ---------------------------------------------------------------------------
module tb_ps2_frame_receiver;

   localparam int SYNC_STAGES = 2;
   localparam int FILTER_LEN  = 8;
   localparam int TIMEOUT_CYC = 500;
   localparam int HALF        = 40;
   // Cycles from driving a PS2_clk fall to the internal bit strobe:
   // two sync flops plus FILTER_LEN disagreeing samples.
   localparam int STROBE_LAT  = SYNC_STAGES + FILTER_LEN;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       PS2_clk = 1'b1;
   logic       PS2_dat = 1'b1;
   logic [7:0] data;
   logic       data_valid;
   logic       parity_err;
   logic       frame_err;
   logic       released;
   logic       extended;

   always #5 clk = ~clk;

   ps2_frame_receiver #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .PS2_clk    (PS2_clk),
      .PS2_dat    (PS2_dat),
      .data       (data),
      .data_valid (data_valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .released   (released),
      .extended   (extended)
   );

   int          checks = 0;
   int          failures = 0;
   int unsigned cyc = 0;
   int unsigned last_fall_cyc = 0;

   int          dv_cnt = 0;
   int          pe_cnt = 0;
   int          fe_cnt = 0;
   int          viol = 0;
   int unsigned dv_cyc = 0;
   int unsigned fe_cyc = 0;
   logic [7:0]  dv_data_q[$];
   logic        dv_rel_q[$];
   logic        dv_ext_q[$];
   logic        prev_dv = 1'b0;
   logic        prev_pe = 1'b0;
   logic        prev_fe = 1'b0;

   int dv0, pe0, fe0;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor: counts pulses, logs delivered bytes, tracks overlap/width.
   always @(negedge clk) begin
      if (reset) begin
         if (data_valid) begin
            dv_cnt++;
            dv_cyc = cyc;
            dv_data_q.push_back(data);
            dv_rel_q.push_back(released);
            dv_ext_q.push_back(extended);
         end
         if (parity_err) pe_cnt++;
         if (frame_err) begin
            fe_cnt++;
            fe_cyc = cyc;
         end
         if ((int'(data_valid) + int'(parity_err) + int'(frame_err)) > 1) viol++;
         if ((prev_dv && data_valid) || (prev_pe && parity_err) || (prev_fe && frame_err)) viol++;
      end
      prev_dv = data_valid;
      prev_pe = parity_err;
      prev_fe = frame_err;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: observed no end of run, expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic snap();
      dv0 = dv_cnt;
      pe0 = pe_cnt;
      fe0 = fe_cnt;
   endtask

   function automatic logic [10:0] mk(input logic [7:0] b, input logic par, input logic stp);
      return {stp, par, b, 1'b0};
   endfunction

   function automatic logic odd_par(input logic [7:0] b);
      return ~^b;
   endfunction

   // Drives the first nbits of a frame; glitch_bit >= 0 adds a 3-cycle low
   // glitch in the high phase following that bit.
   task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_bit);
      PS2_dat = bits[0];
      wait_cyc(HALF);
      for (int i = 0; i < nbits; i++) begin
         PS2_clk = 1'b0;
         last_fall_cyc = cyc;
         wait_cyc(HALF / 2);
         PS2_dat = (i + 1 < nbits) ? bits[i + 1] : 1'b1;
         wait_cyc(HALF / 2);
         PS2_clk = 1'b1;
         if (i == glitch_bit) begin
            wait_cyc(10);
            PS2_clk = 1'b0;
            wait_cyc(3);
            PS2_clk = 1'b1;
            wait_cyc(HALF - 13);
         end else begin
            wait_cyc(HALF);
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_bits(mk(b, odd_par(b), 1'b1), 11, -1);
   endtask

   initial begin
      wait_cyc(5);
      chk("rst_data", data, 8'h00);
      chk("rst_data_valid", data_valid, 1'b0);
      chk("rst_parity_err", parity_err, 1'b0);
      chk("rst_frame_err", frame_err, 1'b0);
      chk("rst_released", released, 1'b0);
      chk("rst_extended", extended, 1'b0);
      reset = 1'b1;
      wait_cyc(20);

      // 1: good frame 0x1C
      snap();
      send_bits(mk(8'h1C, 1'b0, 1'b1), 11, -1);
      chk("t1_dv_count", dv_cnt - dv0, 1);
      chk("t1_data", data, 8'h1C);
      chk("t1_latency", dv_cyc - last_fall_cyc, STROBE_LAT + 1);
      chk("t1_no_perr", pe_cnt - pe0, 0);
      chk("t1_no_ferr", fe_cnt - fe0, 0);

      // 2: parity error
      snap();
      send_bits(mk(8'h1C, 1'b1, 1'b1), 11, -1);
      chk("t2_perr_count", pe_cnt - pe0, 1);
      chk("t2_no_dv", dv_cnt - dv0, 0);
      chk("t2_no_ferr", fe_cnt - fe0, 0);
      chk("t2_data_held", data, 8'h1C);

      // 3: bad stop bit, then 0x45
      snap();
      send_bits(mk(8'h1C, 1'b0, 1'b0), 11, -1);
      chk("t3_ferr_count", fe_cnt - fe0, 1);
      chk("t3_no_perr", pe_cnt - pe0, 0);
      chk("t3_no_dv", dv_cnt - dv0, 0);
      snap();
      send_bits(mk(8'h45, 1'b0, 1'b1), 11, -1);
      chk("t3_dv_45", dv_cnt - dv0, 1);
      chk("t3_data_45", data, 8'h45);

      // 4: abort after 4 data bits, idle past the timeout, then 0x29
      snap();
      send_bits(mk(8'h1C, 1'b0, 1'b1), 5, -1);
      wait_cyc(TIMEOUT_CYC + 150);
      chk("t4_timeout_ferr", fe_cnt - fe0, 1);
      // FSM acts one cycle after the strobe; frame_err follows TIMEOUT_CYC edges later.
      chk("t4_timeout_time", fe_cyc - last_fall_cyc, TIMEOUT_CYC + STROBE_LAT + 1);
      chk("t4_no_dv", dv_cnt - dv0, 0);
      snap();
      send_bits(mk(8'h29, 1'b0, 1'b1), 11, -1);
      chk("t4_dv_29", dv_cnt - dv0, 1);
      chk("t4_data_29", data, 8'h29);
      chk("t4_no_err", (pe_cnt - pe0) + (fe_cnt - fe0), 0);

      // 5: glitches idle and mid-frame, then reset mid-frame
      snap();
      PS2_clk = 1'b0;
      wait_cyc(3);
      PS2_clk = 1'b1;
      wait_cyc(30);
      chk("t5_idle_glitch", (dv_cnt - dv0) + (pe_cnt - pe0) + (fe_cnt - fe0), 0);
      send_bits(mk(8'h45, 1'b0, 1'b1), 11, 3);
      chk("t5_glitch_dv", dv_cnt - dv0, 1);
      chk("t5_glitch_data", data, 8'h45);
      chk("t5_glitch_no_err", (pe_cnt - pe0) + (fe_cnt - fe0), 0);
      snap();
      send_bits(mk(8'h1C, 1'b0, 1'b1), 6, -1);
      reset = 1'b0;
      #1;
      chk("t5_rst_data", data, 8'h00);
      chk("t5_rst_pulses", {data_valid, parity_err, frame_err}, 3'b000);
      chk("t5_rst_qual", {released, extended}, 2'b00);
      wait_cyc(5);
      reset = 1'b1;
      wait_cyc(20);
      chk("t5_rst_no_pulse", (dv_cnt - dv0) + (pe_cnt - pe0) + (fe_cnt - fe0), 0);
      send_byte(8'h1C);
      chk("t5_after_rst_dv", dv_cnt - dv0, 1);
      chk("t5_after_rst_data", data, 8'h1C);

      // 6: prefix sequence E0 F0 75, then 1C
      snap();
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h75);
`ifdef PS2_BREAK_DECODE_EN
      chk("t6_dv_count", dv_cnt - dv0, 1);
      chk("t6_data", dv_data_q[dv_data_q.size() - 1], 8'h75);
      chk("t6_released", dv_rel_q[dv_rel_q.size() - 1], 1'b1);
      chk("t6_extended", dv_ext_q[dv_ext_q.size() - 1], 1'b1);
      chk("t6_hold_qual", {released, extended}, 2'b11);
`else
      chk("t6_dv_count", dv_cnt - dv0, 3);
      chk("t6_data_e0", dv_data_q[dv_data_q.size() - 3], 8'hE0);
      chk("t6_data_f0", dv_data_q[dv_data_q.size() - 2], 8'hF0);
      chk("t6_data_75", dv_data_q[dv_data_q.size() - 1], 8'h75);
      chk("t6_qual_zero", {released, extended}, 2'b00);
`endif
      snap();
      send_byte(8'h1C);
      chk("t6_dv_1c", dv_cnt - dv0, 1);
      chk("t6_data_1c", data, 8'h1C);
      chk("t6_rel_1c", dv_rel_q[dv_rel_q.size() - 1], 1'b0);
      chk("t6_ext_1c", dv_ext_q[dv_ext_q.size() - 1], 1'b0);
      chk("t6_no_err", (pe_cnt - pe0) + (fe_cnt - fe0), 0);

      chk("pulse_exclusive_single", viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
